// File: rtl/slot_allocator.sv
// rtl/slot_allocator.sv - multi-port slot allocator with zero-latency grants and bitmap tracking
module slot_allocator #(
  parameter int SIZE  = 20,
  parameter int NREQ  = 2,
  parameter int NFREE = 2,
  parameter int WIDTH = $clog2(SIZE)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_flush,
  input  logic [NREQ-1:0]        i_req,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ*WIDTH-1:0]  o_idx,
  input  logic [NFREE-1:0]       i_free_en,
  input  logic [NFREE*WIDTH-1:0] i_free_idx,
  output logic [WIDTH:0]         o_free_cnt,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam logic [WIDTH:0] SIZE_CNT = (WIDTH+1)'(SIZE);

  logic [SIZE-1:0]  busy;
  logic [SIZE-1:0]  avail;
  logic [SIZE-1:0]  lowest;
  logic [SIZE-1:0]  take;
  logic [WIDTH-1:0] pick;

  // Each requesting port in ascending order claims the lowest slot not yet taken this cycle
  always_comb begin
    avail  = ~busy;
    take   = '0;
    lowest = '0;
    pick   = '0;
    o_gnt  = '0;
    o_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Isolate the lowest set bit of the remaining free mask
      lowest = avail & (~avail + SIZE'(1));
      pick   = '0;
      for (int i = 0; i < SIZE; i++) begin
        if (lowest[i]) pick = i[WIDTH-1:0];
      end
      // A lower port that was refused leaves no free slot, so this port is refused too
      if (i_en && i_req[k] && (|avail)) begin
        o_gnt[k]                = 1'b1;
        o_idx[k*WIDTH +: WIDTH] = pick;
        take                    = take | lowest;
        avail                   = avail & ~lowest;
      end
    end
  end

  logic [SIZE-1:0]  rel;
  logic [WIDTH-1:0] fidx;

  // Release decode: out-of-range indices never match and duplicates collapse into one bit
  always_comb begin
    rel  = '0;
    fidx = '0;
    for (int j = 0; j < NFREE; j++) begin
      fidx = i_free_idx[j*WIDTH +: WIDTH];
      for (int i = 0; i < SIZE; i++) begin
        if (i_free_en[j] && (fidx == i[WIDTH-1:0])) rel[i] = 1'b1;
      end
    end
  end

  logic [SIZE-1:0] busy_nxt;
  logic [WIDTH:0]  pop;
  logic [WIDTH:0]  free_nxt;

  // Next bitmap and free count derived from it, so the counter can never drift from the bitmap
  always_comb begin
    busy_nxt = i_flush ? '0 : ((busy & ~rel) | take);
    pop      = '0;
    for (int i = 0; i < SIZE; i++) begin
      pop = pop + {{WIDTH{1'b0}}, busy_nxt[i]};
    end
    free_nxt = SIZE_CNT - pop;
  end

  // State register; reset dominates flush, grants and releases
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy       <= '0;
      o_free_cnt <= SIZE_CNT;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
    end else begin
      busy       <= busy_nxt;
      o_free_cnt <= free_nxt;
      o_full     <= (free_nxt == '0);
      o_empty    <= (free_nxt == SIZE_CNT);
    end
  end

endmodule

// File: tb/tb_slot_allocator.sv
// tb/tb_slot_allocator.sv - vector and scoreboard bench for slot_allocator
module tb_slot_allocator;

  localparam int SIZE  = 20;
  localparam int NREQ  = 2;
  localparam int NFREE = 2;
  localparam int WIDTH = 5;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic                   i_en;
  logic                   i_flush;
  logic [NREQ-1:0]        i_req;
  logic [NREQ-1:0]        o_gnt;
  logic [NREQ*WIDTH-1:0]  o_idx;
  logic [NFREE-1:0]       i_free_en;
  logic [NFREE*WIDTH-1:0] i_free_idx;
  logic [WIDTH:0]         o_free_cnt;
  logic                   o_full;
  logic                   o_empty;

  slot_allocator #(.SIZE(SIZE), .NREQ(NREQ), .NFREE(NFREE), .WIDTH(WIDTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_flush    (i_flush),
    .i_req      (i_req),
    .o_gnt      (o_gnt),
    .o_idx      (o_idx),
    .i_free_en  (i_free_en),
    .i_free_idx (i_free_idx),
    .o_free_cnt (o_free_cnt),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       en;
    logic [1:0] req;
    logic [1:0] fen;
    int         fi0;
    int         fi1;
    logic [1:0] egnt;
    int         ei0;
    int         ei1;
    int         ecnt;
  } vec_t;

  typedef struct {
    int cnt;
    int full;
    int empty;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic flush, input logic en,
                              input logic [1:0] req, input logic [1:0] fen,
                              input int fi0, input int fi1, input logic [1:0] egnt,
                              input int ei0, input int ei1, input int ecnt);
    vec_t v;
    v.rst = rst; v.flush = flush; v.en = en; v.req = req; v.fen = fen;
    v.fi0 = fi0; v.fi1 = fi1; v.egnt = egnt; v.ei0 = ei0; v.ei1 = ei1; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, check combinational grants, then check registered state after the edge
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    i_rst      = v.rst;
    i_flush    = v.flush;
    i_en       = v.en;
    i_req      = v.req;
    i_free_en  = v.fen;
    i_free_idx = {v.fi1[WIDTH-1:0], v.fi0[WIDTH-1:0]};
    @(negedge i_clk);
    chk({tag, " gnt"}, int'(o_gnt), int'(v.egnt));
    chk({tag, " idx0"}, int'(o_idx[0 +: WIDTH]), v.ei0);
    chk({tag, " idx1"}, int'(o_idx[WIDTH +: WIDTH]), v.ei1);
    e.cnt   = v.ecnt;
    e.full  = (v.ecnt == 0) ? 1 : 0;
    e.empty = (v.ecnt == SIZE) ? 1 : 0;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    chk({tag, " free_cnt"}, int'(o_free_cnt), e.cnt);
    chk({tag, " full"}, int'(o_full), e.full);
    chk({tag, " empty"}, int'(o_empty), e.empty);
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_flush = 1'b0; i_req = '0;
    i_free_en = '0; i_free_idx = '0;

    //          rst   flsh  en    req    fen    fi0 fi1 egnt   i0  i1  cnt
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0,  0,  2'b00, 0,  0,  20)); // reset state
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0,  0,  2'b11, 0,  1,  18)); // two grants
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 0,  0,  2'b00, 0,  0,  18)); // enable low
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 0,  0,  2'b10, 0,  2,  17)); // port1 alone
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1,  0,  2'b01, 3,  0,  17)); // alloc+release
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0,  0,  2'b11, 1,  4,  15)); // freed slot reused
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 3,  3,  2'b00, 0,  0,  16)); // duplicate release
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 7,  31, 2'b00, 0,  0,  16)); // free / range
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 0,  4,  2'b00, 0,  0,  17)); // release, en low
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 0,  0,  2'b11, 3,  4,  20)); // flush wins
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0,  0,  2'b11, 0,  1,  18)); // after flush
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 0,  0,  2'b11, 2,  3,  20)); // reset wins
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 0,  0,  2'b00, 0,  0,  20)); // idle

    for (int n = 0; n < tbl.size(); n++) begin
      run_vec(tbl[n], $sformatf("vec%0d", n));
    end

    // Fill slots 0..17, then exhaust the last two
    run_vec(mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 20), "fill_rst");
    for (int n = 0; n < 9; n++) begin
      run_vec(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0, 0, 2'b11, 2*n, 2*n+1, 18-2*n),
              $sformatf("fill%0d", n));
    end
    run_vec(mk(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 0, 0, 2'b10, 0, 18, 1), "last_two_p1");
    run_vec(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0, 0, 2'b01, 19, 0, 0), "last_one");
    // Full: release of 5 not grantable in the same cycle
    run_vec(mk(1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 5, 0, 2'b00, 0, 0, 1), "full_rel5");
    run_vec(mk(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 0, 0, 2'b01, 5, 0, 0), "regrant5");
    run_vec(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 0), "full_noreq");

    // Ten busy then flush with requests
    run_vec(mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 20), "fl_rst");
    for (int n = 0; n < 5; n++) begin
      run_vec(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0, 0, 2'b11, 2*n, 2*n+1, 18-2*n),
              $sformatf("fl_fill%0d", n));
    end
    run_vec(mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 0, 0, 2'b11, 10, 11, 20), "flush10");

    // Twelve busy then reset with requests
    for (int n = 0; n < 6; n++) begin
      run_vec(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0, 0, 2'b11, 2*n, 2*n+1, 18-2*n),
              $sformatf("rs_fill%0d", n));
    end
    run_vec(mk(1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 0, 0, 2'b11, 12, 13, 20), "rst12");
    run_vec(mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 0, 0, 2'b11, 0, 1, 18), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
REQ-001 Parameter SIZE, default 20, number of allocatable slots (2..64).
REQ-002 Parameter NREQ, default 2, number of allocation ports (1..4).
REQ-003 Parameter NFREE, default 2, number of release ports (1..4).
REQ-004 Parameter WIDTH, default $clog2(SIZE), slot index width.
REQ-005 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_en  input  1  allocation enable; low forces all grants to 0.
REQ-008 i_flush  input  1  frees every slot at next edge.
REQ-009 i_req  input  NREQ  per-port allocation request.
REQ-010 o_gnt  output  NREQ  per-port grant, combinational from state and inputs.
REQ-011 o_idx  output  NREQ*WIDTH  granted slot index; port k in bits [k*WIDTH +: WIDTH].
REQ-012 i_free_en  input  NFREE  per-port release valid.
REQ-013 i_free_idx  input  NFREE*WIDTH  released slot index; port j in bits [j*WIDTH +: WIDTH].
REQ-014 o_free_cnt  output  WIDTH+1  registered count of free slots.
REQ-015 o_full  output  1  registered; high when o_free_cnt == 0.
REQ-016 o_empty  output  1  registered; high when o_free_cnt == SIZE.

Function
REQ-017 State: SIZE-bit busy bitmap plus free counter; bit i set = slot i allocated.
REQ-018 Grant rule: m = count of ports below k with i_req high; port k granted iff i_en, i_req[k], and at least m+1 free slots exist.
REQ-019 Granted port k receives the (m+1)-th lowest-index free slot; ports therefore receive distinct indices in ascending port order.
REQ-020 o_idx for a non-granted port SHALL be 0.
REQ-021 Grants are zero-latency: o_gnt/o_idx valid in the same cycle as i_req; busy bits for granted slots set at that edge.
REQ-022 Release: for each i_free_en[j], busy bit i_free_idx[j] cleared at the edge; freed slot grantable from the following cycle only, never same cycle.
REQ-023 Release of an already-free slot, or index >= SIZE, is ignored; counter unaffected.
REQ-024 Duplicate release indices in one cycle count once.
REQ-025 Same-cycle allocate and release of different slots both take effect; o_free_cnt(next) = o_free_cnt + effective_releases - grants.
REQ-026 o_free_cnt SHALL equal SIZE minus popcount(busy) at every edge; never wraps below 0 or above SIZE.
REQ-027 i_flush: clears all busy bits, o_free_cnt=SIZE next cycle; overrides same-cycle grants and releases for state update; o_gnt still combinationally driven that cycle but its slots are not recorded.
REQ-028 When o_full, all o_gnt SHALL be 0 regardless of i_req.
REQ-029 i_en low: no state change from allocation; releases and flush still processed.

Reset
REQ-030 i_rst high at edge: busy bitmap all 0, o_free_cnt=SIZE, o_full=0, o_empty=1.
REQ-031 Reset has priority over flush, grants and releases; grants asserted combinationally during reset cycle are discarded.
REQ-032 Reset mid-operation returns all slots to free state in one cycle; no residual allocation.

Verification
REQ-033 After reset, i_en=1, i_req=2'b11 one cycle -> o_gnt=2'b11, o_idx port0=0, port1=1; next cycle o_free_cnt=18.
REQ-034 Busy slots 0..17 (2 free: 18,19), i_req=2'b10 -> port1 gets idx 18; then i_req=2'b11 with only 19 free -> o_gnt=2'b01, port0 idx 19, next o_full=1.
REQ-035 Full state, release idx 5 while i_req=2'b01 -> o_gnt=0 that cycle; next cycle o_gnt=2'b01, o_idx=5.
REQ-036 Release idx 3 twice on both ports with slot 3 busy, plus release free slot 7 -> o_free_cnt increases by exactly 1.
REQ-037 Ten slots busy, i_flush=1 with i_req=2'b11 -> next cycle o_free_cnt=20, o_empty=1, busy all 0.
REQ-038 i_rst asserted while grants active with 12 busy -> next cycle o_free_cnt=20, o_empty=1, o_full=0.
